mp_addsub: RTL and testbench
============================

# mp_addsub

Multi-cycle, multi-precision adder/subtractor for wide field operands. It processes N-bit operands in W-bit limbs, one limb per clock, so a single narrow carry chain replaces a full-width one. It supports add, subtract, add-with-carry-in and subtract-with-borrow-in, and reports carry/borrow and a zero flag. It uses a valid/ready handshake on both sides and sits between the operand register file and the modular-reduction stage of the datapath.

## Interface
- `N`, 256, operand width in bits; must satisfy N % W == 0.
- `W`, 32, limb width in bits (per-cycle carry-chain length).
- `K`, N/W, derived localparam: number of limb beats.

- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  2  operation: 00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
- `cin`  in  1  carry-in (ADDC) or borrow-in (SUBB); ignored for ADD/SUB.
- `a`, `b`  in  N  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  N  a±b mod 2^N.
- `cout`  out  1  carry-out (add ops) or borrow-out (sub ops).
- `zero`  out  1  result == 0.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, capture a, b, op, cin and go to RUN with limb index i=0. Operand changes after capture are ignored.
- Setup on capture:
  - sub = op[0].
  - Initial carry c0 = op[1] ? (sub ? ~cin : cin) : sub.
  - zero accumulator is set to 1.
- RUN, each cycle, limb i:
  - {c, r_i} = a_i + (b_i ^ {W{sub}}) + c, with width W+1.
  - Write r_i into result[i*W +: W].
  - zero accumulator &= (r_i == 0).
  - After i = K-1, go to DONE.
- DONE: out_valid=1.
  - cout = sub ? ~c : c. In sub ops this is the borrow-out, so ~c.
  - result, cout and zero stay stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
- in_valid while not in IDLE is ignored. No queueing.
- K=1 (W==N) is legal: RUN lasts one cycle.
- rst in any state:
  - Go to IDLE and abandon any operation in flight; no out_valid is produced for it.
  - result=0, cout=0, zero=0, out_valid=0, limb index=0.
  - in_ready=0 while rst is high, 1 from the first cycle after rst drops.

## Timing
- Handshake accepted at rising edge 0.
- RUN occupies cycles 1..K.
- out_valid rises in cycle K+1. Latency is K+1 cycles to first out_valid.
- With out_ready held high, out_valid is high for exactly one cycle. in_ready returns the cycle after the output handshake; there is no same-cycle bypass.
- Throughput is one operation per K+2 cycles.
- `result` limbs update during RUN; they are only defined while out_valid=1.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output except none: in_ready and out_valid are decoded from the state register only.

## Structure
- Shared package `mp_arith_pkg`:
  - `mp_op_e` enum (ADD, SUB, ADDC, SUBB).
  - State enum `mp_addsub_state_e`.
  - Default N/W constants, for reuse by the reduction stage.
- Limb datapath: one instance of the existing `rca_add #(.N(W))`.
  - Carry-in is the registered carry.
  - b-limb inversion is done outside the instance, as in `add_sub`.
- Controller (FSM, limb counter of width $clog2(K)+1, carry/zero flags) stays in `mp_addsub`; no further sub-modules.

## Test plan
Parameters N=256, W=32, K=8 unless stated.
- ADD overflow: a=2^256-1, b=1 → result=0, cout=1, zero=1, out_valid exactly at cycle 9 after accept.
- Inter-limb carry: ADD a=0xFFFFFFFF, b=1 → result=0x1_0000_0000, cout=0, zero=0. Also SUB a=5, b=7 → result=2^256-2, cout=1.
- Carry/borrow-in:
  - ADDC cin=1, a=b=0 → result=1, cout=0.
  - SUBB cin=1, a=b=3 → result=2^256-1, cout=1.
  - SUB a=b=0x1234 → result=0, zero=1, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulsing in_valid with new operands → out_valid stays high, result/cout/zero stable, in_ready=0, new operands are not captured. Raising out_ready → in_ready=1 the following cycle.
- Reset mid-RUN: assert rst at cycle 4 after accept for 1 cycle → out_valid never rises, all outputs 0, in_ready=1 the cycle after rst drops. A following ADD 2+3 → result=5.
- Degenerate depth: N=W=64, ADD a=2^64-1, b=2 → result=1, cout=1, out_valid at cycle 2. Back-to-back operations with out_ready tied high → one result every 3 cycles.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// -----------------------------------------------------------------------------
// mp_arith_pkg
// Shared types and constants for the multi-precision arithmetic datapath.
// This package is used by mp_addsub and by the modular-reduction stage that
// follows it.
//   mp_op_e            : operation encoding (ADD, SUB, ADDC, SUBB)
//   mp_addsub_state_e  : controller states of mp_addsub
//   MP_N_DEFAULT/W     : default operand and limb widths
//   init_carry()       : carry to inject into limb 0 for a given op
// -----------------------------------------------------------------------------
package mp_arith_pkg;

    localparam int MP_N_DEFAULT = 256;
    localparam int MP_W_DEFAULT = 32;

    // bit 0 selects subtract, bit 1 selects the carry/borrow-in variants
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } mp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mp_addsub_state_e;

    // Subtraction is a + ~b + 1, so plain SUB injects 1. A borrow-in removes
    // that 1, which is why SUBB injects ~cin.
    function automatic logic init_carry(input mp_op_e op, input logic cin);
        logic sub;
        sub = op[0];
        return op[1] ? (sub ? ~cin : cin) : sub;
    endfunction

endpackage

// File: rtl/mp_addsub_if.sv
// -----------------------------------------------------------------------------
// mp_addsub_if
// Operand/result handshake bundle for mp_addsub.
//   in_valid/in_ready   : operand handshake (op, cin, a, b)
//   out_valid/out_ready : result handshake (result, cout, zero)
// The master modport is the producer/consumer side. The slave modport is
// the arithmetic block.
// -----------------------------------------------------------------------------
interface mp_addsub_if
    import mp_arith_pkg::*;
#(
    parameter int N = MP_N_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    mp_op_e         op;
    logic           cin;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   result;
    logic           cout;
    logic           zero;

    modport master (
        output in_valid, op, cin, a, b, out_ready,
        input  in_ready, out_valid, result, cout, zero
    );

    modport slave (
        input  in_valid, op, cin, a, b, out_ready,
        output in_ready, out_valid, result, cout, zero
    );
endinterface

// File: rtl/rca_add.sv
// -----------------------------------------------------------------------------
// rca_add
// Plain N-bit ripple-carry adder. It has no state.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, mod 2^N
//   cout : carry out of bit N-1
// -----------------------------------------------------------------------------
module rca_add #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
endmodule

// File: rtl/mp_addsub.sv
// -----------------------------------------------------------------------------
// mp_addsub
// Multi-cycle, multi-precision add/subtract. It processes N-bit operands one
// W-bit limb per clock through a single W-bit ripple adder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mp_addsub_if.slave
//              in:  in_valid, op, cin, a, b, out_ready
//              out: in_ready, out_valid, result, cout, zero
// Latency is K+1 cycles from accept to out_valid (K = N/W). One operation
// completes every K+2 cycles. N must be a multiple of W.
// -----------------------------------------------------------------------------
module mp_addsub
    import mp_arith_pkg::*;
#(
    parameter int N = MP_N_DEFAULT,
    parameter int W = MP_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mp_addsub_if.slave bus
);
    localparam int K     = N / W;
    localparam int IDX_W = $clog2(K) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    mp_addsub_state_e state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             sub_q;
    logic             zero_q;
    logic             cout_q;
    logic [N-1:0]     result_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;

    logic [W-1:0]     b_limb;
    logic [W-1:0]     sum_limb;
    logic             carry_nxt;

    // The operand registers shift right one limb per RUN cycle, so the
    // current limb is always in the low W bits.
    assign b_limb = b_q[W-1:0] ^ {W{sub_q}};

    rca_add #(.N(W)) u_rca (
        .a    (a_q[W-1:0]),
        .b    (b_limb),
        .cin  (carry_q),
        .sum  (sum_limb),
        .cout (carry_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)        state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX)   state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)       state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // The handshake flags are decoded from the state register alone. in_ready
    // is also masked by rst, so no operand can be accepted during reset.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) && !rst;
        bus.out_valid = (state_q == ST_DONE);
    end

    // Control, flags and the result register. These are all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            result_q <= '0;
        end else if (state_q == ST_IDLE && bus.in_valid) begin
            idx_q   <= '0;
            sub_q   <= bus.op[0];
            carry_q <= init_carry(bus.op, bus.cin);
            zero_q  <= 1'b1;
        end else if (state_q == ST_RUN) begin
            result_q[idx_q*W +: W] <= sum_limb;
            carry_q <= carry_nxt;
            zero_q  <= zero_q & (sum_limb == '0);
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                idx_q  <= '0;
                // For subtraction, a carry out of a + ~b + c means no borrow.
                cout_q <= sub_q ? ~carry_nxt : carry_nxt;
            end
        end
    end

    // The operand shadow registers are pure data, so reset does not touch them.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end else if (state_q == ST_RUN) begin
            a_q <= a_q >> W;
            b_q <= b_q >> W;
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_mp_addsub.sv
// -----------------------------------------------------------------------------
// tb_mp_addsub
// Directed bench for mp_addsub. It has one 256/32 instance (K=8) and one
// 64/64 instance (K=1). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mp_addsub;
    import mp_arith_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mp_addsub_if #(.N(256)) bus256 ();
    mp_addsub_if #(.N(64))  bus64  ();

    mp_addsub #(.N(256), .W(32)) u_dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256.slave)
    );

    mp_addsub #(.N(64), .W(64)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [255:0] ALL1 = {256{1'b1}};

    typedef struct packed {
        mp_op_e       op;
        logic         cin;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] r;
        logic         co;
        logic         z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ov(input bit w64);
        return w64 ? bus64.out_valid : bus256.out_valid;
    endfunction

    task automatic drive(input bit w64, input logic v, input mp_op_e op, input logic cin,
                         input logic [255:0] a, input logic [255:0] b);
        if (w64) begin
            bus64.in_valid = v;
            bus64.op       = op;
            bus64.cin      = cin;
            bus64.a        = a[63:0];
            bus64.b        = b[63:0];
        end else begin
            bus256.in_valid = v;
            bus256.op       = op;
            bus256.cin      = cin;
            bus256.a        = a;
            bus256.b        = b;
        end
    endtask

    // Present one operation, then wait (bounded) for out_valid. cyc counts
    // cycles after the accepting edge: the first sampled cycle is 1.
    task automatic do_op(input bit w64, input mp_op_e op, input logic cin,
                         input logic [255:0] a, input logic [255:0] b,
                         output logic [255:0] res, output logic co, output logic z,
                         output int cyc);
        drive(w64, 1'b1, op, cin, a, b);
        tick();
        drive(w64, 1'b0, op, cin, a, b);
        cyc = 1;
        while (!ov(w64) && cyc < 40) begin
            tick();
            cyc++;
        end
        if (w64) begin
            res = 256'(bus64.result);
            co  = bus64.cout;
            z   = bus64.zero;
        end else begin
            res = bus256.result;
            co  = bus256.cout;
            z   = bus256.zero;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] res;
        logic         co, z;
        int           cyc;
        bit           saw;
        int           last, npulse;

        vecs[0] = '{OP_ADD,  1'b0, ALL1, 256'd1, 256'd0, 1'b1, 1'b1};
        vecs[1] = '{OP_ADD,  1'b0, 256'hFFFF_FFFF, 256'd1, 256'h1_0000_0000, 1'b0, 1'b0};
        vecs[2] = '{OP_SUB,  1'b0, 256'd5, 256'd7, ALL1 - 256'd1, 1'b1, 1'b0};
        vecs[3] = '{OP_ADDC, 1'b1, 256'd0, 256'd0, 256'd1, 1'b0, 1'b0};
        vecs[4] = '{OP_SUBB, 1'b1, 256'd3, 256'd3, ALL1, 1'b1, 1'b0};
        vecs[5] = '{OP_SUB,  1'b0, 256'h1234, 256'h1234, 256'd0, 1'b0, 1'b1};
        vecs[6] = '{OP_ADD,  1'b0, {160'd0, {96{1'b1}}}, 256'd1, 256'd1 << 96, 1'b0, 1'b0};
        vecs[7] = '{OP_SUB,  1'b0, 256'd1 << 96, 256'd1, {160'd0, {96{1'b1}}}, 1'b0, 1'b0};

        rst = 1'b1;
        bus256.out_ready = 1'b1;
        bus64.out_ready  = 1'b1;
        drive(1'b0, 1'b0, OP_ADD, 1'b0, '0, '0);
        drive(1'b1, 1'b0, OP_ADD, 1'b0, '0, '0);
        tick();
        tick();

        chk("rst_in_ready",  256'(bus256.in_ready),  256'd0);
        chk("rst_out_valid", 256'(bus256.out_valid), 256'd0);
        chk("rst_result",    bus256.result,          256'd0);
        chk("rst_cout",      256'(bus256.cout),      256'd0);
        chk("rst_zero",      256'(bus256.zero),      256'd0);

        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 256'(bus256.in_ready), 256'd1);

        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b, res, co, z, cyc);
            chk($sformatf("v%0d_latency", i), 256'(cyc), 256'd9);
            chk($sformatf("v%0d_result", i),  res,       vecs[i].r);
            chk($sformatf("v%0d_cout", i),    256'(co),  256'(vecs[i].co));
            chk($sformatf("v%0d_zero", i),    256'(z),   256'(vecs[i].z));
            tick();
            chk($sformatf("v%0d_pulse_end", i), 256'(bus256.out_valid), 256'd0);
            chk($sformatf("v%0d_in_ready", i),  256'(bus256.in_ready),  256'd1);
        end

        // Backpressure: result held in DONE while new operands are offered
        bus256.out_ready = 1'b0;
        do_op(1'b0, OP_ADD, 1'b0, 256'd10, 256'd20, res, co, z, cyc);
        chk("bp_latency", 256'(cyc), 256'd9);
        chk("bp_result",  res,       256'd30);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, OP_SUB, 1'b0, 256'd100, 256'd200);
            tick();
            chk($sformatf("bp%0d_out_valid", k), 256'(bus256.out_valid), 256'd1);
            chk($sformatf("bp%0d_result", k),    bus256.result,          256'd30);
            chk($sformatf("bp%0d_cout", k),      256'(bus256.cout),      256'd0);
            chk($sformatf("bp%0d_zero", k),      256'(bus256.zero),      256'd0);
            chk($sformatf("bp%0d_in_ready", k),  256'(bus256.in_ready),  256'd0);
        end
        drive(1'b0, 1'b0, OP_ADD, 1'b0, '0, '0);
        bus256.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready",  256'(bus256.in_ready),  256'd1);
        chk("bp_release_out_valid", 256'(bus256.out_valid), 256'd0);

        // Reset in the middle of RUN
        drive(1'b0, 1'b1, OP_ADD, 1'b0, ALL1, 256'd1);
        tick();
        drive(1'b0, 1'b0, OP_ADD, 1'b0, '0, '0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready",  256'(bus256.in_ready),  256'd0);
        chk("midrst_out_valid", 256'(bus256.out_valid), 256'd0);
        chk("midrst_result",    bus256.result,          256'd0);
        chk("midrst_cout",      256'(bus256.cout),      256'd0);
        chk("midrst_zero",      256'(bus256.zero),      256'd0);
        rst = 1'b0;
        tick();
        chk("midrst_release_in_ready", 256'(bus256.in_ready), 256'd1);
        saw = 1'b0;
        repeat (12) begin
            tick();
            if (bus256.out_valid) saw = 1'b1;
        end
        chk("midrst_no_out_valid", 256'(saw), 256'd0);
        do_op(1'b0, OP_ADD, 1'b0, 256'd2, 256'd3, res, co, z, cyc);
        chk("after_rst_result", res, 256'd5);
        chk("after_rst_cout",   256'(co), 256'd0);
        tick();

        // Single-limb instance
        do_op(1'b1, OP_ADD, 1'b0, 256'hFFFF_FFFF_FFFF_FFFF, 256'd2, res, co, z, cyc);
        chk("k1_latency", 256'(cyc), 256'd2);
        chk("k1_result",  res,       256'd1);
        chk("k1_cout",    256'(co),  256'd1);
        chk("k1_zero",    256'(z),   256'd0);
        tick();
        chk("k1_pulse_end", 256'(bus64.out_valid), 256'd0);
        chk("k1_in_ready",  256'(bus64.in_ready),  256'd1);

        // Back-to-back with in_valid and out_ready held high
        drive(1'b1, 1'b1, OP_ADD, 1'b0, 256'd5, 256'd6);
        last   = -1;
        npulse = 0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (bus64.out_valid) begin
                if (last >= 0) chk($sformatf("b2b_gap%0d", npulse), 256'(t - last), 256'd3);
                chk($sformatf("b2b_result%0d", npulse), 256'(bus64.result), 256'd11);
                last = t;
                npulse++;
            end
        end
        chk("b2b_pulses", 256'(npulse), 256'd5);
        drive(1'b1, 1'b0, OP_ADD, 1'b0, '0, '0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
